// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package sev_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    GUARD = 2'd2
  } scanState_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sev_seg_lut.sv
// Hex nibble to active-high seven-segment pattern, purely combinational.
module sev_seg_lut
  import sev_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup of the segment pattern for one nibble
  always_comb begin
    pattern = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with guard gaps, leading-zero
// blanking and a shadowed load handshake that only swaps at frame start.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int ON_CYC    = 8,
  parameter int GUARD_CYC = 2,
  parameter int LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic        load_ready,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int MAX_CYC = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scanState_t       stateR, stateS;
  logic [IDX_W-1:0] idxR, idxS;
  logic [CNT_W-1:0] cntR, cntS;
  logic [15:0]      dispR, dispS, shadowR;
  logic [3:0]       dpR, dpS, shadowDpR;
  logic             pendingR, pendingS;
  logic             loadXferS, copyS;
  logic [3:0]       nibbleS;
  logic [6:0]       patternS;
  logic             blankS;

  // Scan sequencing: IDLE -> ON(idx) -> GUARD -> ON(idx+1) ..., en=0 forces IDLE
  always_comb begin
    stateS = stateR;
    idxS   = idxR;
    cntS   = cntR;
    if (!en) begin
      stateS = IDLE;
      idxS   = '0;
      cntS   = '0;
    end else begin
      case (stateR)
        IDLE: begin
          stateS = ON;
          idxS   = '0;
          cntS   = '0;
        end
        ON: begin
          if (cntR == ON_LAST) begin
            stateS = GUARD;
            cntS   = '0;
          end else begin
            cntS = cntR + CNT_W'(1);
          end
        end
        GUARD: begin
          if (cntR == GUARD_LAST) begin
            stateS = ON;
            idxS   = idxR + IDX_W'(1);
            cntS   = '0;
          end else begin
            cntS = cntR + CNT_W'(1);
          end
        end
        default: begin
          stateS = IDLE;
          idxS   = '0;
          cntS   = '0;
        end
      endcase
    end
  end

  // Load handshake; the shadow only reaches the display at digit-0 entry or in IDLE
  always_comb begin
    loadXferS = load_valid && !pendingR;
    copyS     = pendingR && ((stateR == IDLE) ||
                ((stateS == ON) && (idxS == '0) && (stateR != ON)));
    if (copyS) begin
      dispS    = shadowR;
      dpS      = shadowDpR;
      pendingS = 1'b0;
    end else begin
      dispS    = dispR;
      dpS      = dpR;
      pendingS = loadXferS ? 1'b1 : pendingR;
    end
  end

  // Digit selection and leading-zero blanking for the digit about to be shown
  always_comb begin
    case (idxS)
      2'd0: begin
        nibbleS = dispS[3:0];
        blankS  = 1'b0;
      end
      2'd1: begin
        nibbleS = dispS[7:4];
        blankS  = (dispS[15:4] == 12'h000);
      end
      2'd2: begin
        nibbleS = dispS[11:8];
        blankS  = (dispS[15:8] == 8'h00);
      end
      2'd3: begin
        nibbleS = dispS[15:12];
        blankS  = (dispS[15:12] == 4'h0);
      end
      default: begin
        nibbleS = 4'h0;
        blankS  = 1'b0;
      end
    endcase
    if (LZ_BLANK == 0) begin
      blankS = 1'b0;
    end else begin
      blankS = blankS;
    end
  end

  sev_seg_lut uLut (
    .nibble  (nibbleS),
    .pattern (patternS)
  );

  // State, data and output registers; outputs are built from next-state values
  // so anodes, segments and decimal point all switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR     <= IDLE;
      idxR       <= '0;
      cntR       <= '0;
      dispR      <= 16'h0000;
      dpR        <= 4'h0;
      shadowR    <= 16'h0000;
      shadowDpR  <= 4'h0;
      pendingR   <= 1'b0;
      an_n       <= 4'hF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      stateR     <= stateS;
      idxR       <= idxS;
      cntR       <= cntS;
      dispR      <= dispS;
      dpR        <= dpS;
      shadowR    <= loadXferS ? load_data : shadowR;
      shadowDpR  <= loadXferS ? load_dp : shadowDpR;
      pendingR   <= pendingS;
      an_n       <= (stateS == ON) ? ~(4'b0001 << idxS) : 4'hF;
      seg_n      <= ((stateS == ON) && !blankS) ? ~patternS : 7'h7F;
      dp_n       <= (stateS == ON) ? ~dpS[idxS] : 1'b1;
      load_ready <= ~pendingS;
      frame_done <= (stateR == GUARD) && (idxR == LAST_IDX) && (cntR == GUARD_LAST);
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed self-checking bench for sev_seg_scan_ctrl (ON_CYC=8, GUARD_CYC=2).
module tb_sev_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic [3:0]  load_dp = 4'h0;
  logic        load_ready;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;

  sev_seg_scan_ctrl #(.ON_CYC(8), .GUARD_CYC(2), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_data(load_data),
    .load_dp(load_dp), .load_ready(load_ready), .an_n(an_n), .seg_n(seg_n),
    .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // advance n clock edges, leaving time 1 unit past the last edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load_valid = 1'b1; load_data = 16'hBEEF; load_dp = 4'hF;
    tick(1);
    compared++; if (an_n !== 4'hF) begin mismatched++; $display("FAIL reset_an: got %h want F", an_n); end
    compared++; if (seg_n !== 7'h7F) begin mismatched++; $display("FAIL reset_seg: got %h want 7F", seg_n); end
    compared++; if (dp_n !== 1'b1) begin mismatched++; $display("FAIL reset_dp: got %b want 1", dp_n); end
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst = 1'b0; en = 1'b0; load_valid = 1'b0;
    tick(1);
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL reset_load_discard: got %b want 1", load_ready); end
  endtask

  // one full frame from ON entry: digit = c/10, anode lit for c%10 < 8
  task automatic test_scan();
    logic [3:0] expAn;
    int pulses;
    pulses = 0;
    en = 1'b1;
    tick(1);
    for (int c = 0; c <= 40; c++) begin
      expAn = ((c % 10) < 8) ? ~(4'b0001 << ((c / 10) % 4)) : 4'hF;
      compared++; if (an_n !== expAn) begin mismatched++; $display("FAIL scan_an c=%0d: got %h want %h", c, an_n, expAn); end
      compared++; if (frame_done !== (c == 40)) begin mismatched++; $display("FAIL scan_fd c=%0d: got %b want %b", c, frame_done, (c == 40)); end
      if (frame_done === 1'b1) pulses++;
      if (c < 40) tick(1);
    end
    compared++; if (pulses != 1) begin mismatched++; $display("FAIL scan_fd_count: got %0d want 1", pulses); end
  endtask

  task automatic test_load_idle();
    en = 1'b0;
    tick(1);
    compared++; if (an_n !== 4'hF) begin mismatched++; $display("FAIL idle_an: got %h want F", an_n); end
    load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'h0;
    tick(1);
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL idle_ready_low: got %b want 0", load_ready); end
    load_valid = 1'b0;
    tick(1);
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL idle_ready_back: got %b want 1", load_ready); end
    en = 1'b1;
    tick(1);
    compared++; if (seg_n !== 7'h19 || an_n !== 4'hE) begin mismatched++; $display("FAIL l1234_d0: got %h/%h want 19/E", seg_n, an_n); end
    tick(10);
    compared++; if (seg_n !== 7'h30 || an_n !== 4'hD) begin mismatched++; $display("FAIL l1234_d1: got %h/%h want 30/D", seg_n, an_n); end
    tick(8);
    compared++; if (seg_n !== 7'h7F || an_n !== 4'hF) begin mismatched++; $display("FAIL l1234_guard: got %h/%h want 7F/F", seg_n, an_n); end
    tick(2);
    compared++; if (seg_n !== 7'h24 || an_n !== 4'hB) begin mismatched++; $display("FAIL l1234_d2: got %h/%h want 24/B", seg_n, an_n); end
    tick(10);
    compared++; if (seg_n !== 7'h79 || an_n !== 4'h7) begin mismatched++; $display("FAIL l1234_d3: got %h/%h want 79/7", seg_n, an_n); end
    compared++; if (dp_n !== 1'b1) begin mismatched++; $display("FAIL l1234_dp: got %b want 1", dp_n); end
  endtask

  // load 00A5 with dp on digit 2 during digit 0 of a frame
  task automatic test_midframe_load();
    tick(10);
    compared++; if (seg_n !== 7'h19 || an_n !== 4'hE) begin mismatched++; $display("FAIL mid_old_d0: got %h/%h want 19/E", seg_n, an_n); end
    load_valid = 1'b1; load_data = 16'h00A5; load_dp = 4'b0100;
    tick(1);
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL mid_ready_drop: got %b want 0", load_ready); end
    load_data = 16'hFFFF; load_dp = 4'hF;
    tick(1);
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL mid_ready_hold: got %b want 0", load_ready); end
    load_valid = 1'b0;
    tick(8);
    compared++; if (seg_n !== 7'h30 || an_n !== 4'hD) begin mismatched++; $display("FAIL mid_old_d1: got %h/%h want 30/D", seg_n, an_n); end
    tick(29);
    compared++; if (load_ready !== 1'b0 || an_n !== 4'hF) begin mismatched++; $display("FAIL mid_frame_end: got %b/%h want 0/F", load_ready, an_n); end
    tick(1);
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready_rise: got %b want 1", load_ready); end
    compared++; if (seg_n !== 7'h12 || an_n !== 4'hE || dp_n !== 1'b1) begin mismatched++; $display("FAIL new_d0: got %h/%h/%b want 12/E/1", seg_n, an_n, dp_n); end
    tick(10);
    compared++; if (seg_n !== 7'h08 || an_n !== 4'hD) begin mismatched++; $display("FAIL new_d1: got %h/%h want 08/D", seg_n, an_n); end
    tick(10);
    compared++; if (seg_n !== 7'h7F || an_n !== 4'hB || dp_n !== 1'b0) begin mismatched++; $display("FAIL new_d2: got %h/%h/%b want 7F/B/0", seg_n, an_n, dp_n); end
    tick(7);
    compared++; if (dp_n !== 1'b0) begin mismatched++; $display("FAIL dp_d2_last: got %b want 0", dp_n); end
    tick(1);
    compared++; if (dp_n !== 1'b1 || an_n !== 4'hF) begin mismatched++; $display("FAIL dp_guard: got %b/%h want 1/F", dp_n, an_n); end
    tick(2);
    compared++; if (seg_n !== 7'h7F || an_n !== 4'h7 || dp_n !== 1'b1) begin mismatched++; $display("FAIL new_d3: got %h/%h/%b want 7F/7/1", seg_n, an_n, dp_n); end
  endtask

  task automatic test_zero_blank();
    en = 1'b0;
    tick(1);
    load_valid = 1'b1; load_data = 16'h0000; load_dp = 4'h0;
    tick(1);
    load_valid = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1);
    compared++; if (seg_n !== 7'h40 || an_n !== 4'hE) begin mismatched++; $display("FAIL zero_d0: got %h/%h want 40/E", seg_n, an_n); end
    tick(10);
    compared++; if (seg_n !== 7'h7F || an_n !== 4'hD) begin mismatched++; $display("FAIL zero_d1: got %h/%h want 7F/D", seg_n, an_n); end
    tick(10);
    compared++; if (seg_n !== 7'h7F || an_n !== 4'hB) begin mismatched++; $display("FAIL zero_d2: got %h/%h want 7F/B", seg_n, an_n); end
    tick(10);
    compared++; if (seg_n !== 7'h7F || an_n !== 4'h7) begin mismatched++; $display("FAIL zero_d3: got %h/%h want 7F/7", seg_n, an_n); end
  endtask

  task automatic test_en_drop();
    tick(33);
    compared++; if (an_n !== 4'hB) begin mismatched++; $display("FAIL drop_pre: got %h want B", an_n); end
    en = 1'b0;
    tick(1);
    compared++; if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin mismatched++; $display("FAIL drop_blank: got %h/%h/%b want F/7F/1", an_n, seg_n, dp_n); end
    tick(1);
    compared++; if (an_n !== 4'hF) begin mismatched++; $display("FAIL drop_hold: got %h want F", an_n); end
    en = 1'b1;
    tick(1);
    compared++; if (an_n !== 4'hE || seg_n !== 7'h40) begin mismatched++; $display("FAIL drop_restart: got %h/%h want E/40", an_n, seg_n); end
  endtask

  task automatic test_rst_during_load();
    rst = 1'b1; load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'hF;
    tick(1);
    compared++; if (load_ready !== 1'b1 || an_n !== 4'hF || frame_done !== 1'b0) begin mismatched++; $display("FAIL rst_load: got %b/%h/%b want 1/F/0", load_ready, an_n, frame_done); end
    rst = 1'b0; load_valid = 1'b0;
    tick(1);
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL rst_no_pending: got %b want 1", load_ready); end
    compared++; if (an_n !== 4'hE || seg_n !== 7'h40 || dp_n !== 1'b1) begin mismatched++; $display("FAIL rst_restart: got %h/%h/%b want E/40/1", an_n, seg_n, dp_n); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_idle();
    test_midframe_load();
    test_zero_blank();
    test_en_drop();
    test_rst_during_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
